// File: rtl/hamming_enc_pipe.sv
// -----------------------------------------------------------------------------
// hamming_enc_pipe
//
// Parametrised two-stage pipelined Hamming SEC encoder with valid/ready
// handshakes on both sides and a free-running count of emitted codewords.
//
// Codeword layout (shared with the decoder): 1-based position j = index+1.
// Power-of-two positions carry parity; all other positions carry data in
// ascending order, in_data[0] at index 2. Parity at 2^k is even parity over
// every data position whose position number has bit k set.
//
// Compile-time option: HAM_ENC_SECDED_EN
//    defined   : one extra MSB holds even parity over all other codeword bits
//                (SECDED); computed alongside the SEC bits, latency unchanged.
//    undefined : plain SEC codeword, ENC_W = DATA_W + PAR_W.
//
// Ports
//    clk        in   1       clock, rising edge
//    rst        in   1       asynchronous active-high reset
//    in_data    in   DATA_W  payload word
//    in_valid   in   1       payload valid
//    in_ready   out  1       encoder accepts a payload this cycle
//    out_data   out  ENC_W   encoded codeword (reads 0 after reset)
//    out_valid  out  1       codeword valid
//    out_ready  in   1       sink accepts the codeword this cycle
//    word_cnt   out  CNT_W   count of output handshakes, wraps silently
// -----------------------------------------------------------------------------
module hamming_enc_pipe #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   // Smallest P with 2^P >= DATA_W + P + 1.
   localparam int PAR_W = $clog2(DATA_W + $clog2(DATA_W) + 1),
`ifdef HAM_ENC_SECDED_EN
   localparam int ENC_W = DATA_W + PAR_W + 1
`else
   localparam int ENC_W = DATA_W + PAR_W
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ENC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int HAM_W = DATA_W + PAR_W;

   // Elaboration-time helpers for building the position map.
   function automatic bit is_pow2(input int j);
      return (j & (j - 1)) == 0;
   endfunction

   function automatic int log2_floor(input int j);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++)
         if (((j >> b) & 1) != 0) r = b;
      return r;
   endfunction

   // Data bit index carried at position j (number of data slots below j).
   function automatic int data_idx(input int j);
      int n;
      n = 0;
      for (int i = 1; i < j; i++)
         if (!is_pow2(i)) n++;
      return n;
   endfunction

   // Coverage mask of parity bit 2^k: data positions with bit k set.
   function automatic logic [HAM_W-1:0] par_mask(input int k);
      logic [HAM_W-1:0] m;
      m = '0;
      for (int j = 1; j <= HAM_W; j++)
         if (!is_pow2(j) && (((j >> k) & 1) != 0)) m[j-1] = 1'b1;
      return m;
   endfunction

   logic              s1_valid;
   logic              s2_valid;
   logic [DATA_W-1:0] s1_data;
   logic              s2_ready;
   logic [HAM_W-1:0]  ham_data;
   logic [HAM_W-1:0]  ham_cw;
   logic [PAR_W-1:0]  par;
   logic [ENC_W-1:0]  enc_cw;

   // ---------------------------------------------------------------- encode
   // ham_data has the payload scattered into its slots with parity slots
   // zero; parity is reduced from it so ham_cw never feeds back into itself.
   for (genvar j = 1; j <= HAM_W; j++) begin : g_pos
      if (is_pow2(j)) begin : g_par_slot
         assign ham_data[j-1] = 1'b0;
         assign ham_cw[j-1]   = par[log2_floor(j)];
      end else begin : g_data_slot
         assign ham_data[j-1] = s1_data[data_idx(j)];
         assign ham_cw[j-1]   = ham_data[j-1];
      end
   end

   for (genvar k = 0; k < PAR_W; k++) begin : g_par
      localparam logic [HAM_W-1:0] MASK = par_mask(k);
      assign par[k] = ^(ham_data & MASK);
   end

`ifdef HAM_ENC_SECDED_EN
   assign enc_cw = {^ham_cw, ham_cw};
`else
   assign enc_cw = ham_cw;
`endif

   // -------------------------------------------------------------- pipeline
   assign s2_ready  = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_ready;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         out_data <= '0;
         word_cnt <= '0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (s2_ready) begin
            s2_valid <= s1_valid;
            // Hold the last codeword when S2 drains so out_data only ever
            // shows 0 or a genuine codeword.
            if (s1_valid) out_data <= enc_cw;
         end
         if (s2_valid && out_ready) word_cnt <= word_cnt + 1'b1;
      end
   end

   // Payload register needs no reset; its content is qualified by s1_valid.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) s1_data <= in_data;
   end

endmodule

// File: tb/tb_hamming_enc_pipe.sv
// -----------------------------------------------------------------------------
// Directed bench for hamming_enc_pipe: reset values, fixed vectors, latency,
// backpressure, full-rate streaming, counter wrap (CNT_W=4 instance) and
// reset with words in flight.
// -----------------------------------------------------------------------------
module tb_hamming_enc_pipe;

`ifdef HAM_ENC_SECDED_EN
   localparam int ENC_W = 39;
   localparam logic [ENC_W-1:0] EXP_ONE  = 39'h4000000007;
   localparam logic [ENC_W-1:0] EXP_ONES = 39'h3F7FFFFFF4;
`else
   localparam int ENC_W = 38;
   localparam logic [ENC_W-1:0] EXP_ONE  = 38'h0000000007;
   localparam logic [ENC_W-1:0] EXP_ONES = 38'h3F7FFFFFF4;
`endif

   logic             clk;
   logic             rst;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic [ENC_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      word_cnt;

   logic             in_valid4;
   logic             in_ready4;
   logic [ENC_W-1:0] out_data4;
   logic             out_valid4;
   logic             out_ready4;
   logic [3:0]       word_cnt4;

   int n_checks;
   int n_errors;

   hamming_enc_pipe #(.DATA_W(32), .CNT_W(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_cnt  (word_cnt)
   );

   hamming_enc_pipe #(.DATA_W(32), .CNT_W(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .word_cnt  (word_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scatter data, XOR the positions of all set data bits into a
   // syndrome, and drop that syndrome into the parity slots so the full
   // codeword's syndrome is zero.
   function automatic logic [ENC_W-1:0] model(input logic [31:0] d);
      logic [37:0] cw;
      logic [5:0]  syn;
      int          di;
      cw  = '0;
      syn = '0;
      di  = 0;
      for (int j = 1; j <= 38; j++) begin
         if ((j & (j - 1)) != 0) begin
            cw[j-1] = d[di];
            if (d[di]) syn = syn ^ 6'(j);
            di++;
         end
      end
      for (int k = 0; k < 6; k++) cw[(1 << k) - 1] = syn[k];
`ifdef HAM_ENC_SECDED_EN
      return {^cw, cw};
`else
      return cw;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   logic [31:0]      bp_words [5];
   logic [ENC_W-1:0] exp_q [$];
   logic [ENC_W-1:0] exp_w;
   int               sent;
   int               recv;

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      in_data    = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      bp_words[0] = 32'h12345678;
      bp_words[1] = 32'hDEADBEEF;
      bp_words[2] = 32'h00000000;
      bp_words[3] = 32'h80000000;
      bp_words[4] = 32'hA5A5A5A5;

      // ---- reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_word_cnt",  64'(word_cnt),  64'd0);
      check("rst_word_cnt4", 64'(word_cnt4), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // ---- in_data = 1, latency 2
      in_data   = 32'h00000001;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("one_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      #1;
      check("one_lat1_valid", 64'(out_valid), 64'd0);
      tick();
      check("one_lat2_valid", 64'(out_valid), 64'd1);
      check("one_data",       64'(out_data),  64'(EXP_ONE));
      check("one_cnt_before", 64'(word_cnt),  64'd0);
      tick();
      check("one_cnt",        64'(word_cnt),  64'd1);
      check("one_drained",    64'(out_valid), 64'd0);

      // ---- all ones
      in_data  = 32'hFFFFFFFF;
      in_valid = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      tick();
      check("ones_valid", 64'(out_valid), 64'd1);
      check("ones_data",  64'(out_data),  64'(EXP_ONES));
      tick();
      check("ones_cnt",   64'(word_cnt),  64'd2);

      // ---- backpressure: out_ready low for the first 4 cycles
      do_reset();
      sent = 0;
      recv = 0;
      for (int i = 0; i < 12; i++) begin
         out_ready = (i >= 4);
         in_valid  = (sent < 5);
         if (sent < 5) in_data = bp_words[sent];
         #1;
         if (i == 2 || i == 3) check("bp_in_ready_low", 64'(in_ready), 64'd0);
         if (out_valid) begin
            if (recv < 5) check("bp_out_data", 64'(out_data), 64'(model(bp_words[recv])));
            else          check("bp_extra_word", 64'(out_valid), 64'd0);
         end
         if (in_valid && in_ready)   sent++;
         if (out_valid && out_ready) recv++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("bp_sent",     64'(sent),      64'd5);
      check("bp_recv",     64'(recv),      64'd5);
      check("bp_word_cnt", 64'(word_cnt),  64'd5);
      check("bp_empty",    64'(out_valid), 64'd0);

      // ---- full rate, random data
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 100; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = $urandom;
         #1;
         check("fr_in_ready", 64'(in_ready), 64'd1);
         if (out_valid) begin
            if (exp_q.size() > 0) begin
               exp_w = exp_q.pop_front();
               check("fr_out_data", 64'(out_data), 64'(exp_w));
            end else begin
               check("fr_extra_word", 64'(out_valid), 64'd0);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_data));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("fr_word_cnt", 64'(word_cnt), 64'd98);

      // ---- 4-bit counter wrap: 17 handoffs
      do_reset();
      for (int i = 0; i < 20; i++) begin
         check("wrap_cnt", 64'(word_cnt4), 64'(((i >= 2) ? (i - 2) : 0) & 15));
         if (i == 2) check("wrap_valid", 64'(out_valid4), 64'd1);
         in_valid4  = (i < 19);
         out_ready4 = (i < 19);
         in_data    = 32'(i);
         #1;
         tick();
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      check("wrap_final", 64'(word_cnt4), 64'd1);

      // ---- reset with two words in flight
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h00000001;
      #1;
      tick();
      in_data = 32'hFFFFFFFF;
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      check("inflight_valid", 64'(out_valid), 64'd1);
      check("inflight_data",  64'(out_data),  64'(EXP_ONE));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_data",  64'(out_data),  64'd0);
      tick();
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("rel_no_stale", 64'(out_valid), 64'd0);
         tick();
      end
      in_data  = 32'h00000010;
      in_valid = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      check("rel_lat1_valid", 64'(out_valid), 64'd0);
      tick();
      check("rel_lat2_valid", 64'(out_valid), 64'd1);
      check("rel_data",       64'(out_data),  64'(model(32'h00000010)));
      tick();
      check("rel_word_cnt",   64'(word_cnt),  64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
